// File: rtl/textcon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : textcon_pkg
// Description : Shared types, control-code constants and register packing
//               helper for the textcon console front end.
// Revision    : 1.0 - initial release
// ============================================================================
package textcon_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLR_LINE   = 2'd1,
        CLR_SCREEN = 2'd2
    } state_t;

    localparam logic [7:0] CC_BS  = 8'h08;
    localparam logic [7:0] CC_LF  = 8'h0A;
    localparam logic [7:0] CC_FF  = 8'h0C;
    localparam logic [7:0] CC_CR  = 8'h0D;
    localparam logic [6:0] CH_BAD = 7'h3F;

    // Display write register layout: [20:16] x, [12:8] y, [6:0] char.
    function automatic logic [31:0] pack_char(input logic [4:0] x,
                                              input logic [4:0] y,
                                              input logic [6:0] ch);
        return {11'b0, x, 3'b0, y, 1'b0, ch};
    endfunction

endpackage
`default_nettype wire

// File: rtl/textcon_clear.sv
`default_nettype none
// ============================================================================
// Module      : textcon_clear
// Description : Column/row sweep counter used to blank one line or the whole
//               screen, one position per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module textcon_clear
    import textcon_pkg::*;
#(
    parameter int COLS           = 32,
    parameter int ROWS           = 28,
    parameter bit START_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_line,
    input  logic       start_screen,
    input  logic [4:0] row,
    output logic [4:0] x,
    output logic [4:0] y,
    output logic       active,
    output logic       done
);

    localparam logic [4:0] LAST_COL = 5'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    logic screen;

    // done pulses the cycle after the final position was presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            x      <= 5'd0;
            y      <= 5'd0;
            active <= START_ON_RESET;
            screen <= 1'b1;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_screen) begin
                x      <= 5'd0;
                y      <= 5'd0;
                active <= 1'b1;
                screen <= 1'b1;
            end else if (start_line) begin
                x      <= 5'd0;
                y      <= row;
                active <= 1'b1;
                screen <= 1'b0;
            end else if (active) begin
                if (x == LAST_COL) begin
                    x <= 5'd0;
                    if (!screen || y == LAST_ROW) begin
                        active <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        y <= y + 5'd1;
                    end
                end else begin
                    x <= x + 5'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/textcon.sv
`default_nettype none
// ============================================================================
// Module      : textcon
// Description : Character-stream console front end: byte handshake, cursor
//               tracking, control-code decode and display write generation.
// Revision    : 1.0 - initial release
// ============================================================================
module textcon
    import textcon_pkg::*;
#(
    parameter int         COLS           = 32,
    parameter int         ROWS           = 28,
    parameter logic [7:0] BLANK          = 8'h20,
    parameter int         CLEAR_ON_RESET = 1
) (
    input  logic        wclk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [3:0]  char_we,
    output logic [31:0] char_di,
    output logic [4:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic        busy
);

    localparam logic [4:0] LAST_COL = 5'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_t      state;
    state_t      state_nx;
    logic [4:0]  x_nx;
    logic [4:0]  y_nx;
    logic [3:0]  we_nx;
    logic [31:0] di_nx;
    logic [4:0]  next_row;
    logic        printable;
    logic        start_line;
    logic        start_screen;
    logic [4:0]  clr_x;
    logic [4:0]  clr_y;
    logic        clr_active;
    logic        clr_done;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign next_row  = (cur_y == LAST_ROW) ? 5'd0 : cur_y + 5'd1;
    // 0x7F falls outside both printable ranges and is simply consumed.
    assign printable = in_data[7] || (in_data >= 8'h20 && in_data <= 8'h7E);

    textcon_clear #(
        .COLS           (COLS),
        .ROWS           (ROWS),
        .START_ON_RESET (CLEAR_ON_RESET != 0)
    ) u_clear (
        .clk          (wclk),
        .rst          (reset),
        .start_line   (start_line),
        .start_screen (start_screen),
        .row          (next_row),
        .x            (clr_x),
        .y            (clr_y),
        .active       (clr_active),
        .done         (clr_done)
    );

    always_comb begin
        state_nx     = state;
        x_nx         = cur_x;
        y_nx         = cur_y;
        we_nx        = 4'b0000;
        di_nx        = char_di;
        start_line   = 1'b0;
        start_screen = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_data == CC_CR) begin
                        x_nx = 5'd0;
                    end else if (in_data == CC_LF) begin
                        x_nx       = 5'd0;
                        y_nx       = next_row;
                        start_line = 1'b1;
                        state_nx   = CLR_LINE;
                    end else if (in_data == CC_BS) begin
                        if (cur_x != 5'd0) begin
                            x_nx  = cur_x - 5'd1;
                            we_nx = 4'b1111;
                            di_nx = pack_char(cur_x - 5'd1, cur_y, BLANK[6:0]);
                        end
                    end else if (in_data == CC_FF) begin
                        start_screen = 1'b1;
                        state_nx     = CLR_SCREEN;
                    end else if (printable) begin
                        we_nx = 4'b1111;
                        di_nx = pack_char(cur_x, cur_y,
                                          in_data[7] ? CH_BAD : in_data[6:0]);
                        if (cur_x == LAST_COL) begin
                            x_nx       = 5'd0;
                            y_nx       = next_row;
                            start_line = 1'b1;
                            state_nx   = CLR_LINE;
                        end else begin
                            x_nx = cur_x + 5'd1;
                        end
                    end
                end
            end
            CLR_LINE, CLR_SCREEN: begin
                if (clr_active) begin
                    we_nx = 4'b1111;
                    di_nx = pack_char(clr_x, clr_y, BLANK[6:0]);
                end
                if (clr_done) begin
                    state_nx = IDLE;
                    if (state == CLR_SCREEN) begin
                        x_nx = 5'd0;
                        y_nx = 5'd0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (reset) begin
            if (CLEAR_ON_RESET != 0) begin
                state <= CLR_SCREEN;
            end else begin
                state <= IDLE;
            end
            cur_x   <= 5'd0;
            cur_y   <= 5'd0;
            char_we <= 4'b0000;
            char_di <= 32'd0;
        end else begin
            state   <= state_nx;
            cur_x   <= x_nx;
            cur_y   <= y_nx;
            char_we <= we_nx;
            char_di <= di_nx;
        end
    end

endmodule
`default_nettype wire

// File: doc/textcon.md
Name: textcon

Overview:
- Character-stream console front end for the 32x28 overlay text display.
- Accepts bytes from the PicoRV32 I/O bridge over a valid/ready handshake and tracks a cursor.
- Interprets the CR, LF, BS and FF control codes and handles line wrap.
- Emits one character-write per cycle in the display's register format: [20:16] x, [12:8] y, [6:0] char, with we on any byte-enable bit.
- Firmware prints strings without computing coordinates.

Parameters:
- COLS, 32, columns per row; cursor x range 0..COLS-1.
- ROWS, 28, rows per screen; cursor y range 0..ROWS-1.
- BLANK, 8'h20, character written when clearing.
- CLEAR_ON_RESET, 1, when 1 the full screen is cleared after reset.

Ports:
- wclk  in  1  main logic clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- char_we  out  4  4'b1111 for one cycle per character write, else 4'b0000.
- char_di  out  32  {11'b0, x[4:0], 3'b0, y[4:0], 1'b0, ch[6:0]}.
- cur_x  out  5  current cursor column.
- cur_y  out  5  current cursor row.
- busy  out  1  high while a line or screen clear is in progress.

Behaviour:
- Reset:
  - char_we=0, char_di=0, cur_x=0, cur_y=0.
  - State goes to CLR_SCREEN if CLEAR_ON_RESET=1, else IDLE.
  - Reset asserted mid-clear aborts the clear immediately and restarts per CLEAR_ON_RESET.
- States:
  - IDLE: in_ready=1. A byte is accepted on the cycle in_valid=1.
  - CLR_LINE: in_ready=0. Writes BLANK to (0..COLS-1, clr_row), one column per cycle, ascending. After column COLS-1 -> IDLE.
  - CLR_SCREEN: in_ready=0. Writes BLANK row-major from (0,0) to (COLS-1,ROWS-1), COLS*ROWS=896 writes. Then cursor=(0,0) -> IDLE.
  - busy = (state != IDLE).
- Outputs are registered. The write for a byte accepted in cycle N appears on char_we/char_di in cycle N+1, for exactly one cycle. In clear states, one write per cycle back-to-back.
- Byte handling in IDLE (cursor values shown are post-update, visible cycle N+1):
  - 0x20..0x7E:
    - Write ch at (cur_x,cur_y), then cur_x+1.
    - If cur_x was COLS-1: cur_x=0, cur_y=next row, enter CLR_LINE on the new row.
  - 0x80..0xFF: same as printable, but ch=7'h3F ('?').
  - 0x0D CR: cur_x=0, no write.
  - 0x0A LF: cur_x=0, cur_y=next row, enter CLR_LINE on the new row.
  - 0x08 BS: if cur_x>0, cur_x-1 and write BLANK at the new position; if cur_x=0, no-op (no write, no row change).
  - 0x0C FF: enter CLR_SCREEN.
  - Other 0x00..0x1F: consumed, no write, cursor unchanged.
- Next row = cur_y+1, wrapping ROWS-1 -> 0. No scrolling: the display buffer is write-only. Clearing the destination row gives a clean line.
- Coordinates are 5-bit. Width truncation is never relied on; wrap compares against COLS-1/ROWS-1 explicitly.
- A byte presented while busy is held by the source (in_ready=0). in_data need not be stable until accepted.
- char_di[31:21], [15:13] and [7] are always 0.

Decomposition:
- Package textcon_pkg: state enum (IDLE, CLR_LINE, CLR_SCREEN); control-code constants CC_BS=8'h08, CC_LF=8'h0A, CC_FF=8'h0C, CC_CR=8'h0D, CH_BAD=7'h3F; helper for packing {x,y,ch} into char_di.
- One sub-module, textcon_clear: column/row sweep counter.
  - Inputs: start_line, start_screen, row.
  - Outputs: x, y, active, done.
  - The top level owns the cursor, decode and output registers.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> exactly 896 writes of 0x20, first (0,0), last (31,27); busy high throughout; in_ready rises the cycle after the last write; cursor (0,0).
- Send "AB" back-to-back -> writes (0,0,'A') then (1,0,'B') on consecutive cycles, one cycle after each accept; cursor (2,0).
- Cursor (31,5), send 'Z' -> write (31,5,'Z'); cursor (0,6); then 32 BLANK writes on row 6 with in_ready=0; next byte accepted only after the last of them.
- Cursor (3,27), send 0x0A -> cursor (0,0); row 0 cleared (32 writes); send 0x08 at x=0 -> no write, cursor unchanged.
- Cursor (4,2): send 0x08 -> write (3,2,0x20), cursor (3,2); send 0xC1 -> write (3,2,0x3F); send 0x07 -> no write, cursor (4,2).
- Send 0x0C, assert reset at write 100 -> clear restarts from (0,0); 896 total writes after reset release.
